rx_phase_ctrl: RTL and testbench
================================

RX_PHASE_CTRL -- requirements
Module: rx_phase_ctrl

Interface
REQ-001 Parameters SHALL be: DIV, default 4, clocks per sample strobe (>=2); NB_IN, default 19, filter-output width; WIN_LOG2, default 8, log2 of symbols per measurement window; PHASE_OFS, default 0, fixed pipeline alignment offset added mod 4 to the selected phase.
REQ-002 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-003 i_run  in  1  level; 1 = acquire/track, 0 = return to IDLE.
REQ-004 i_filt  in  NB_IN  signed filter output, sampled only on o_enable cycles.
REQ-005 i_man_en  in  1  manual phase override.
REQ-006 i_man_phase  in  2  phase used while i_man_en=1.
REQ-007 o_enable  out  1  one-cycle sample strobe to the rx datapath.
REQ-008 o_phase  out  2  downsampling phase select to the rx datapath.
REQ-009 o_locked  out  1  automatic phase valid.
REQ-010 o_busy  out  1  high in ACQ and DECIDE.

Function
REQ-011 The divider counter SHALL count 0..DIV-1 and wrap, running whenever rst=0 regardless of i_run; o_enable SHALL be 1 exactly when the counter is DIV-1.
REQ-012 The 2-bit sample-phase counter ph SHALL increment, wrapping 3->0, on each o_enable cycle.
REQ-013 The FSM states SHALL be IDLE, ACQ, DECIDE, TRACK; IDLE->ACQ on the first o_enable cycle with ph=0 and i_run=1.
REQ-014 In ACQ and TRACK, on each o_enable cycle, |i_filt| SHALL be added into acc[ph]; |-2^(NB_IN-1)| saturates to 2^(NB_IN-1)-1.
REQ-015 Each acc SHALL be unsigned, NB_IN-1+WIN_LOG2 bits wide, and never overflow.
REQ-016 The symbol counter SHALL increment on each o_enable cycle with ph=3; after the 2^WIN_LOG2-th such cycle, the FSM SHALL enter DECIDE for exactly one clock.
REQ-017 DECIDE SHALL compute best = argmax(acc[0..3]) with ties resolved to the lowest index, and clear all acc and the symbol counter.
REQ-018 Leaving DECIDE, the FSM SHALL enter TRACK. o_enable strobes falling in DECIDE are not accumulated; with DIV>=2 none can occur, since DECIDE follows a ph=3 strobe.
REQ-019 First DECIDE after ACQ: the candidate phase cand SHALL become (best+PHASE_OFS) mod 4 immediately, and o_locked SHALL become 1 in the next cycle.
REQ-020 DECIDE from TRACK (hysteresis): cand SHALL change only when the same new best wins two consecutive windows; a single disagreeing window SHALL leave cand and o_locked unchanged.
REQ-021 o_phase SHALL be registered: i_man_phase when i_man_en=1, else cand, updated one cycle after the source changes.
REQ-022 Manual override SHALL NOT stop measurement.
REQ-023 i_run=0 in any state SHALL return the FSM to IDLE next cycle, clear acc, the symbol counter and the hysteresis record, and set o_locked=0; cand SHALL hold.
REQ-024 o_busy SHALL be 1 in ACQ and DECIDE-after-ACQ only.

Reset
REQ-025 rst=1 SHALL force: divider=0, ph=0, FSM=IDLE, all acc=0, symbol counter=0, cand=0, hysteresis cleared, o_enable=0, o_phase=0, o_locked=0, o_busy=0; reset mid-window discards the partial window.
REQ-026 The rx datapath SHALL share rst so that its internal phase counter stays aligned with ph.

Verification
REQ-027 DIV=4, rst released -> o_enable pulses on cycles 3, 7, 11, ..., with ph=0 at the first pulse.
REQ-028 WIN_LOG2=2, i_run=1, i_filt=+100 on ph=2 and 0 otherwise -> DECIDE after 4 symbols, acc[2]=400, o_phase=2, o_locked=1, o_busy=0.
REQ-029 Equal magnitude 50 on ph=1 and ph=3 -> o_phase=1 (tie to lowest index).
REQ-030 Locked at 2, one window favouring 0, then windows favouring 2 -> o_phase stays 2; two consecutive windows favouring 0 -> o_phase=0.
REQ-031 i_filt=-2^18 for a full window (NB_IN=19) -> acc equals 2^WIN_LOG2*(2^18-1), with no wrap.
REQ-032 i_man_en=1, i_man_phase=3 while locked at 1 -> o_phase=3 next cycle; after i_man_en=0 -> o_phase=1. rst or i_run=0 mid-ACQ -> o_locked=0 and acc cleared.

Source files
------------

// File: rtl/rx_phase_ctrl_if.sv
// Control/status bundle between the rx front end and the phase controller.
// master drives the run/filter/override inputs; slave is the controller itself.
interface rx_phase_ctrl_if #(
    parameter int NB_IN = 19
);
    logic                    i_run;
    logic signed [NB_IN-1:0] i_filt;
    logic                    i_man_en;
    logic [1:0]              i_man_phase;
    logic                    o_enable;
    logic [1:0]              o_phase;
    logic                    o_locked;
    logic                    o_busy;

    modport master (
        output i_run, i_filt, i_man_en, i_man_phase,
        input  o_enable, o_phase, o_locked, o_busy
    );

    modport slave (
        input  i_run, i_filt, i_man_en, i_man_phase,
        output o_enable, o_phase, o_locked, o_busy
    );
endinterface

// File: rtl/rx_phase_ctrl.sv
// Receive downsampling-phase controller: picks the sample phase with the largest
// accumulated filter magnitude per window, with two-window hysteresis once locked.
module rx_phase_ctrl #(
    parameter int DIV       = 4,
    parameter int NB_IN     = 19,
    parameter int WIN_LOG2  = 8,
    parameter int PHASE_OFS = 0
) (
    input logic            clk,
    input logic            rst,
    rx_phase_ctrl_if.slave bus
);
    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int ACC_W = NB_IN - 1 + WIN_LOG2;

    typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, DECIDE = 2'd2, TRACK = 2'd3} state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [1:0]              ph_q, ph_d;
    logic [ACC_W-1:0]        acc_q [4];
    logic [ACC_W-1:0]        acc_d [4];
    logic [WIN_LOG2-1:0]     sym_q, sym_d;
    logic [1:0]              cand_q, cand_d;
    logic                    locked_q, locked_d;
    logic                    hyst_vld_q, hyst_vld_d;
    logic [1:0]              hyst_ph_q, hyst_ph_d;
    logic [1:0]              phase_q, phase_d;
    logic                    enable;
    logic [1:0]              best;
    logic [1:0]              new_ph;
    logic signed [NB_IN-1:0] filt;

    // |x| with the most negative code clipped to the largest positive magnitude
    function automatic logic [NB_IN-2:0] abs_sat(input logic signed [NB_IN-1:0] x);
        logic signed [NB_IN-1:0] neg;
        neg = -x;
        if (x == {1'b1, {(NB_IN-1){1'b0}}})
            return '1;
        else if (x[NB_IN-1])
            return neg[NB_IN-2:0];
        else
            return x[NB_IN-2:0];
    endfunction

    assign filt   = bus.i_filt;
    assign enable = (div_q == DIV_W'(DIV - 1));

    always_comb begin
        div_d = enable ? '0 : div_q + DIV_W'(1);
        ph_d  = enable ? ph_q + 2'd1 : ph_q;
    end

    // Strict '>' while scanning upward keeps ties on the lowest index
    always_comb begin
        best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (acc_q[i] > acc_q[best])
                best = 2'(i);
        end
        new_ph = best + 2'(PHASE_OFS);
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sym_d      = sym_q;
        cand_d     = cand_q;
        locked_d   = locked_q;
        hyst_vld_d = hyst_vld_q;
        hyst_ph_d  = hyst_ph_q;

        unique case (state_q)
            IDLE: begin
                if (enable && ph_q == 2'd0 && bus.i_run)
                    state_d = ACQ;
            end
            ACQ, TRACK: begin
                if (enable) begin
                    acc_d[ph_q] = acc_q[ph_q] + ACC_W'(abs_sat(filt));
                    if (ph_q == 2'd3) begin
                        sym_d = sym_q + WIN_LOG2'(1);
                        if (sym_q == '1)
                            state_d = DECIDE;
                    end
                end
            end
            DECIDE: begin
                state_d = TRACK;
                sym_d   = '0;
                for (int i = 0; i < 4; i++)
                    acc_d[i] = '0;
                if (!locked_q) begin
                    cand_d     = new_ph;
                    locked_d   = 1'b1;
                    hyst_vld_d = 1'b0;
                end else if (new_ph == cand_q) begin
                    hyst_vld_d = 1'b0;
                end else if (hyst_vld_q && hyst_ph_q == new_ph) begin
                    cand_d     = new_ph;
                    hyst_vld_d = 1'b0;
                end else begin
                    hyst_vld_d = 1'b1;
                    hyst_ph_d  = new_ph;
                end
            end
        endcase

        // Dropping run abandons the window but keeps the last chosen phase
        if (!bus.i_run) begin
            state_d    = IDLE;
            sym_d      = '0;
            locked_d   = 1'b0;
            hyst_vld_d = 1'b0;
            for (int i = 0; i < 4; i++)
                acc_d[i] = '0;
        end
    end

    assign phase_d = bus.i_man_en ? bus.i_man_phase : cand_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            ph_q       <= 2'd0;
            sym_q      <= '0;
            cand_q     <= 2'd0;
            locked_q   <= 1'b0;
            hyst_vld_q <= 1'b0;
            hyst_ph_q  <= 2'd0;
            phase_q    <= 2'd0;
            for (int i = 0; i < 4; i++)
                acc_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            ph_q       <= ph_d;
            sym_q      <= sym_d;
            cand_q     <= cand_d;
            locked_q   <= locked_d;
            hyst_vld_q <= hyst_vld_d;
            hyst_ph_q  <= hyst_ph_d;
            phase_q    <= phase_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.o_enable = enable;
    assign bus.o_phase  = phase_q;
    assign bus.o_locked = locked_q;
    assign bus.o_busy   = (state_q == ACQ) || (state_q == DECIDE && !locked_q);

endmodule

// File: tb/tb_rx_phase_ctrl.sv
// Directed bench for rx_phase_ctrl with DIV=4, NB_IN=19, WIN_LOG2=2 (16 strobes per window).
module tb_rx_phase_ctrl;
    localparam int DIV      = 4;
    localparam int NB_IN    = 19;
    localparam int WIN_LOG2 = 2;
    localparam longint SAT  = 262143;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic signed [NB_IN-1:0] pat [4];
    logic [1:0]              tb_ph;
    logic [11:0]             en_vec;
    bit                      seen;

    rx_phase_ctrl_if #(.NB_IN(NB_IN)) bus ();

    rx_phase_ctrl #(
        .DIV(DIV), .NB_IN(NB_IN), .WIN_LOG2(WIN_LOG2), .PHASE_OFS(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Bench-side sample-phase tracker; the filter value is chosen per phase
    always @(posedge clk) begin
        if (rst)
            tb_ph <= 2'd0;
        else if (bus.o_enable)
            tb_ph <= tb_ph + 2'd1;
    end
    assign bus.i_filt = pat[tb_ph];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic set_pat(input int p0, input int p1, input int p2, input int p3);
        pat[0] = NB_IN'(p0);
        pat[1] = NB_IN'(p1);
        pat[2] = NB_IN'(p2);
        pat[3] = NB_IN'(p3);
    endtask

    task automatic wait_decide(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(dut.state_q) != 2 && n < 400);
        chk(tag, int'(dut.state_q), 2);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.i_run       = 1'b0;
        bus.i_man_en    = 1'b0;
        bus.i_man_phase = 2'd0;
        set_pat(0, 0, 0, 0);

        // Reset state
        cycles(3);
        chk("rst_enable", bus.o_enable, 0);
        chk("rst_phase",  bus.o_phase, 0);
        chk("rst_locked", bus.o_locked, 0);
        chk("rst_busy",   bus.o_busy, 0);

        // Strobe cadence after release: cycles 3, 7, 11 with ph=0 first
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            en_vec[c] = bus.o_enable;
            if (bus.o_enable && !seen) begin
                seen = 1'b1;
                chk("first_strobe_ph", dut.ph_q, 0);
            end
            @(negedge clk);
        end
        chk("enable_pattern", en_vec, 12'b1000_1000_1000);

        // Single-phase energy on ph=2
        set_pat(0, 0, 100, 0);
        bus.i_run = 1'b1;
        wait_decide("decide_acq2");
        chk("acc2_400", dut.acc_q[2], 400);
        chk("acc0_0",   dut.acc_q[0], 0);
        chk("busy_decide_acq", bus.o_busy, 1);
        cycles(3);
        chk("lock2_locked", bus.o_locked, 1);
        chk("lock2_phase",  bus.o_phase, 2);
        chk("lock2_busy",   bus.o_busy, 0);

        // Dropping run clears lock and accumulators, keeps o_phase
        bus.i_run = 1'b0;
        cycles(1);
        chk("runoff_locked", bus.o_locked, 0);
        chk("runoff_acc2",   dut.acc_q[2], 0);
        chk("runoff_busy",   bus.o_busy, 0);
        chk("runoff_phase",  bus.o_phase, 2);

        // Tie between ph=1 and ph=3 resolves to 1
        set_pat(0, 50, 0, -50);
        bus.i_run = 1'b1;
        wait_decide("decide_tie");
        chk("tie_acc1", dut.acc_q[1], 200);
        chk("tie_acc3", dut.acc_q[3], 200);
        cycles(3);
        chk("tie_phase", bus.o_phase, 1);

        // Hysteresis: lock at 2, then 0 / 2 / 0 / 0 windows
        bus.i_run = 1'b0;
        cycles(2);
        set_pat(0, 0, 100, 0);
        bus.i_run = 1'b1;
        wait_decide("decide_hA");
        set_pat(100, 0, 0, 0);
        cycles(3);
        chk("hA_phase", bus.o_phase, 2);
        wait_decide("decide_hB");
        chk("hB_busy", bus.o_busy, 0);
        set_pat(0, 0, 100, 0);
        cycles(3);
        chk("hB_phase", bus.o_phase, 2);
        wait_decide("decide_hC");
        set_pat(100, 0, 0, 0);
        cycles(3);
        chk("hC_phase", bus.o_phase, 2);
        wait_decide("decide_hD");
        cycles(3);
        chk("hD_phase", bus.o_phase, 2);
        chk("hD_locked", bus.o_locked, 1);
        wait_decide("decide_hE");
        cycles(3);
        chk("hE_phase", bus.o_phase, 0);
        chk("hE_locked", bus.o_locked, 1);

        // Manual override while locked at 1; measurement keeps running
        bus.i_run = 1'b0;
        cycles(2);
        set_pat(0, 100, 0, 0);
        bus.i_run = 1'b1;
        wait_decide("decide_m1");
        cycles(3);
        chk("man_base_phase", bus.o_phase, 1);
        bus.i_man_en    = 1'b1;
        bus.i_man_phase = 2'd3;
        cycles(1);
        chk("man_phase3", bus.o_phase, 3);
        wait_decide("decide_during_man");
        chk("man_acc1", dut.acc_q[1], 400);
        chk("man_hold3", bus.o_phase, 3);
        bus.i_man_en = 1'b0;
        cycles(1);
        chk("man_release", bus.o_phase, 1);

        // Most negative input saturates to 2^18-1 per sample
        bus.i_run = 1'b0;
        cycles(2);
        set_pat(-262144, -262144, -262144, -262144);
        bus.i_run = 1'b1;
        wait_decide("decide_sat_acq");
        chk("sat_acc1", dut.acc_q[1], 4 * SAT);
        wait_decide("decide_sat_trk");
        chk("sat_acc0", dut.acc_q[0], 4 * SAT);

        // run=0 and rst mid-acquisition
        bus.i_run = 1'b0;
        cycles(2);
        set_pat(100, 100, 100, 100);
        bus.i_run = 1'b1;
        cycles(30);
        chk("midacq_busy", bus.o_busy, 1);
        bus.i_run = 1'b0;
        cycles(1);
        chk("midacq_runoff_acc1", dut.acc_q[1], 0);
        chk("midacq_runoff_busy", bus.o_busy, 0);
        bus.i_run = 1'b1;
        cycles(30);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("midacq_rst_locked", bus.o_locked, 0);
        chk("midacq_rst_acc2",   dut.acc_q[2], 0);
        chk("midacq_rst_phase",  bus.o_phase, 0);
        chk("midacq_rst_busy",   bus.o_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
